board_cell_mux: RTL and testbench
=================================

// Module: board_cell_mux
// PURPOSE
//   Nine-way, 8-bit selector for the tic-tac-toe datapath. Picks one of nine
//   board-cell bytes (in1..in9) by a 4-bit cell index and presents it,
//   registered, to downstream game logic (win check, display).
//   Sits between the board register file and its consumers. One clock domain.
// PARAMETERS
//   WIDTH     8   data width of each input and of out
//   N_INPUTS  9   number of selectable inputs; fixed at 9 for this block
//   ERR_VAL   0   value driven on out when sel is out of range (WIDTH bits)
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   en       in   1      capture enable; out/flags update only when high
//   sel      in   4      cell index, 0..8 valid
//   in1..in9 in   8 ea   cell data; sel=k selects in(k+1)
//   out      out  8      registered selected data
//   out_vld  out  1      registered: last capture had a valid sel
//   sel_err  out  1      registered: last capture had sel > 8
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
//   - All outputs are registered. rst is sampled on the rising clk edge and
//     has priority over en.
//   - Reset values: out=0, out_vld=0, sel_err=0.
//   - Selection mapping:
//       sel 0 -> in1, 1 -> in2, 2 -> in3, 3 -> in4, 4 -> in5,
//       5 -> in6, 6 -> in7, 7 -> in8, 8 -> in9.
//   - Latency: 1 cycle. On an edge with en=1 and rst=0, sel and in1..in9
//     are sampled and the result appears on out after that edge.
//   - Valid capture (en=1, sel<=8):
//       out <= selected input, out_vld <= 1, sel_err <= 0.
//   - Out-of-range capture (en=1, sel 9..15):
//       out <= ERR_VAL, out_vld <= 0, sel_err <= 1.
//   - Hold (en=0): out, out_vld and sel_err keep their values, even if sel
//     or the inputs change.
//   - X/Z on sel with en=1: treat as out of range. out=ERR_VAL, sel_err=1.
//     No X may propagate to out_vld or sel_err.
//   - Input changes between edges have no effect on out.
//   - rst asserted in the same cycle as en=1: reset wins, capture discarded.
//   - No handshake and no back-pressure. A new capture is accepted every
//     cycle that en is high.
//   - Pure datapath: no arithmetic and no state beyond the output registers.
// TESTING
//   1. rst=1 for 2 cycles, inputs in1..in9 = 1..9
//      -> out=0, out_vld=0, sel_err=0.
//   2. rst=0, en=1, sweep sel 0..8 one value per cycle
//      -> out = sel+1 one cycle later (1..9), out_vld=1, sel_err=0 throughout.
//   3. en=1, sel=4'd9, then sel=4'd15
//      -> out=0, out_vld=0, sel_err=1 after each edge.
//   4. Capture sel=3 (out=4), then en=0, sel=7, in4 changed to 8'hAA
//      -> out stays 4 and out_vld stays 1 while en=0.
//   5. en=1, sel=5 with rst=1 on the same edge
//      -> out=0, out_vld=0. Next edge with rst=0 -> out=6.
//   6. sel stays fixed at 2 while in3 changes 8'h00 -> 8'hFF -> 8'h5A on
//      successive cycles, en=1 -> out follows in3 with exactly 1-cycle lag.

Source files
------------

// File: rtl/board_cell_mux.sv
// Nine-way board-cell selector with registered output; 1-cycle latency from sel/inN to out.
// No handshake or backpressure: a capture is taken on every edge where en is high.
module board_cell_mux #(
  parameter int                WIDTH    = 8,
  parameter int                N_INPUTS = 9,
  parameter logic [WIDTH-1:0]  ERR_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             sel_err
);

  localparam logic [3:0] LAST_SEL = 4'(N_INPUTS - 1);

  logic             sel_ok;
  logic [WIDTH-1:0] mux_dat;

  // An unknown sel falls to the default arm, so X never reaches the data path.
  always_comb begin
    sel_ok  = (sel <= LAST_SEL);
    mux_dat = ERR_VAL;
    case (sel)
      4'd0:    mux_dat = in1;
      4'd1:    mux_dat = in2;
      4'd2:    mux_dat = in3;
      4'd3:    mux_dat = in4;
      4'd4:    mux_dat = in5;
      4'd5:    mux_dat = in6;
      4'd6:    mux_dat = in7;
      4'd7:    mux_dat = in8;
      4'd8:    mux_dat = in9;
      default: mux_dat = ERR_VAL;
    endcase
  end

  // Flags are loaded from constants in each branch, so an X sel_ok takes the
  // error branch rather than leaking X onto out_vld or sel_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      out_vld <= 1'b0;
      sel_err <= 1'b0;
    end else if (en) begin
      if (sel_ok) begin
        out     <= mux_dat;
        out_vld <= 1'b1;
        sel_err <= 1'b0;
      end else begin
        out     <= ERR_VAL;
        out_vld <= 1'b0;
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_cell_mux.sv
// Scoreboard bench for board_cell_mux: a reference model pushes expected
// outputs per driven edge; each scenario task pops and compares them.
module tb_board_cell_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] sel;
  logic [7:0] cells [9];
  logic [7:0] out;
  logic       out_vld;
  logic       sel_err;

  typedef struct packed {
    logic [7:0] dat;
    logic       vld;
    logic       err;
  } exp_t;

  exp_t sb [$];
  exp_t model;
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  board_cell_mux #(.WIDTH(8), .N_INPUTS(9), .ERR_VAL(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sel    (sel),
    .in1    (cells[0]),
    .in2    (cells[1]),
    .in3    (cells[2]),
    .in4    (cells[3]),
    .in5    (cells[4]),
    .in6    (cells[5]),
    .in7    (cells[6]),
    .in8    (cells[7]),
    .in9    (cells[8]),
    .out    (out),
    .out_vld(out_vld),
    .sel_err(sel_err)
  );

  // Drive one edge's worth of stimulus at the falling edge, push the model's
  // expectation, and return just after the rising edge that captures it.
  task automatic tick(input logic r, input logic en_i, input logic [3:0] s);
    @(negedge clk);
    rst = r;
    en  = en_i;
    sel = s;
    if (r)
      model = '0;
    else if (en_i) begin
      if (s <= 4'd8) model = '{dat: cells[int'(s)], vld: 1'b1, err: 1'b0};
      else           model = '{dat: 8'h00,          vld: 1'b0, err: 1'b1};
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cells();
    for (int i = 0; i < 9; i++) cells[i] = 8'(i + 1);
  endtask

  task automatic test_reset();
    reset_cells();
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 1'b0, 4'd0);
      e = sb.pop_front();
      checks++;
      if ({out, out_vld, sel_err} !== e) begin
        errors++;
        $display("FAIL reset cyc=%0d: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
                 c, out, out_vld, sel_err, e.dat, e.vld, e.err);
      end
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 9; s++) begin
      tick(1'b0, 1'b1, 4'(s));
      e = sb.pop_front();
      checks++;
      if ({out, out_vld, sel_err} !== e || out !== 8'(s + 1)) begin
        errors++;
        $display("FAIL sweep sel=%0d: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
                 s, out, out_vld, sel_err, e.dat, e.vld, e.err);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] bad [2];
    bad[0] = 4'd9;
    bad[1] = 4'd15;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, bad[i]);
      e = sb.pop_front();
      checks++;
      if ({out, out_vld, sel_err} !== e || sel_err !== 1'b1) begin
        errors++;
        $display("FAIL range sel=%0d: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
                 bad[i], out, out_vld, sel_err, e.dat, e.vld, e.err);
      end
    end
    // Error state must also be held while en is low.
    tick(1'b0, 1'b0, 4'd1);
    e = sb.pop_front();
    checks++;
    if ({out, out_vld, sel_err} !== e) begin
      errors++;
      $display("FAIL range_hold: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
               out, out_vld, sel_err, e.dat, e.vld, e.err);
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 1'b1, 4'd3);
    e = sb.pop_front();
    checks++;
    if ({out, out_vld, sel_err} !== e || out !== 8'd4) begin
      errors++;
      $display("FAIL hold_capture: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
               out, out_vld, sel_err, e.dat, e.vld, e.err);
    end
    cells[3] = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0, 4'd7);
      e = sb.pop_front();
      checks++;
      if ({out, out_vld, sel_err} !== e || out !== 8'd4) begin
        errors++;
        $display("FAIL hold cyc=%0d: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
                 c, out, out_vld, sel_err, e.dat, e.vld, e.err);
      end
    end
    reset_cells();
  endtask

  task automatic test_reset_priority();
    tick(1'b1, 1'b1, 4'd5);
    e = sb.pop_front();
    checks++;
    if ({out, out_vld, sel_err} !== e || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
               out, out_vld, sel_err, e.dat, e.vld, e.err);
    end
    tick(1'b0, 1'b1, 4'd5);
    e = sb.pop_front();
    checks++;
    if ({out, out_vld, sel_err} !== e || out !== 8'd6) begin
      errors++;
      $display("FAIL rst_release: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
               out, out_vld, sel_err, e.dat, e.vld, e.err);
    end
  endtask

  task automatic test_follow();
    logic [7:0] seq [3];
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      cells[2] = seq[i];
      tick(1'b0, 1'b1, 4'd2);
      e = sb.pop_front();
      checks++;
      if ({out, out_vld, sel_err} !== e || out !== seq[i]) begin
        errors++;
        $display("FAIL follow i=%0d: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
                 i, out, out_vld, sel_err, e.dat, e.vld, e.err);
      end
    end
    reset_cells();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 9; i++) cells[i] = 8'($urandom_range(0, 255));
      tick(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      e = sb.pop_front();
      checks++;
      if ({out, out_vld, sel_err} !== e) begin
        errors++;
        $display("FAIL b2b cyc=%0d sel=%0d en=%b: got out=%h vld=%b err=%b, want out=%h vld=%b err=%b",
                 c, sel, en, out, out_vld, sel_err, e.dat, e.vld, e.err);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    sel   = 4'd0;
    model = '0;
    reset_cells();
    test_reset();
    test_sweep();
    test_out_of_range();
    test_hold();
    test_reset_priority();
    test_follow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
